// File: rtl/cordic_pkg.sv
// Shared definitions for the folded CORDIC engine:
// mode codes, FSM encoding and the elaboration-time arctangent table.
package cordic_pkg;

    localparam int FUNC_ROT = 0;
    localparam int FUNC_VEC = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // atan(2^-i) scaled so that 2^(width-1) LSB equals pi, rounded to nearest
    function automatic int atan_angle(input int i, input int width);
        real r;
        r = $atan(1.0 / (2.0 ** i)) * (2.0 ** (width - 1))
            / 3.14159265358979323846;
        return $rtoi(r + 0.5);
    endfunction

endpackage

// File: rtl/cordic_microrot.sv
// One CORDIC micro-rotation with a runtime shift amount.
// Purely combinational; all arithmetic wraps at W bits.
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int W  = 18,
    parameter int FW = 1,
    parameter int CW = 4
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic signed [W-1:0]  z,
    input  logic [CW-1:0]        shift,
    input  logic [FW-1:0]        func,
    input  logic signed [W-1:0]  angle,
    output logic signed [W-1:0]  x_next,
    output logic signed [W-1:0]  y_next,
    output logic signed [W-1:0]  z_next
);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic                vec;
    logic                cw;

    always_comb begin
        xs  = x >>> shift;
        ys  = y >>> shift;
        // any code other than vectoring is treated as rotation
        vec = (func == FW'(FUNC_VEC));
        cw  = vec ? (x[W-1] == y[W-1]) : z[W-1];
        if (cw) begin
            x_next = x + ys;
            y_next = y - xs;
            z_next = z + angle;
        end else begin
            x_next = x - ys;
            y_next = y + xs;
            z_next = z - angle;
        end
    end

endmodule

// File: rtl/cordic_iter_engine.sv
// Folded CORDIC: one shared micro-rotation stage reused for NUM_ITER clocks,
// with valid/ready handshakes on both sides and uncompensated gain.
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int NUM_ITER      = 12,
    parameter int DATA_OP_WIDTH = 18,
    parameter int FUNC_WIDTH    = 1,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [FUNC_WIDTH-1:0]           i_func,
    input  logic [TAG_WIDTH-1:0]            i_tag,
    input  logic signed [DATA_OP_WIDTH-1:0] i_x,
    input  logic signed [DATA_OP_WIDTH-1:0] i_y,
    input  logic signed [DATA_OP_WIDTH-1:0] i_z,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic signed [DATA_OP_WIDTH-1:0] o_x,
    output logic signed [DATA_OP_WIDTH-1:0] o_y,
    output logic signed [DATA_OP_WIDTH-1:0] o_z,
    output logic [FUNC_WIDTH-1:0]           o_func,
    output logic [TAG_WIDTH-1:0]            o_tag
);

    localparam int W  = DATA_OP_WIDTH;
    localparam int CW = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_ITER - 1);

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic signed [W-1:0]     wx;
    logic signed [W-1:0]     wy;
    logic signed [W-1:0]     wz;
    logic [FUNC_WIDTH-1:0]   wfunc;
    logic [TAG_WIDTH-1:0]    wtag;
    logic signed [W-1:0]     nx;
    logic signed [W-1:0]     ny;
    logic signed [W-1:0]     nz;
    logic signed [W-1:0]     angle;
    logic signed [W-1:0]     angle_rom [NUM_ITER];

    for (genvar g = 0; g < NUM_ITER; g++) begin : g_rom
        assign angle_rom[g] = W'(atan_angle(g, W));
    end

    assign angle   = angle_rom[cnt];
    assign o_ready = (state == ST_IDLE) | ((state == ST_DONE) & i_ready);

    cordic_microrot #(
        .W  (W),
        .FW (FUNC_WIDTH),
        .CW (CW)
    ) u_microrot (
        .x      (wx),
        .y      (wy),
        .z      (wz),
        .shift  (cnt),
        .func   (wfunc),
        .angle  (angle),
        .x_next (nx),
        .y_next (ny),
        .z_next (nz)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wx      <= '0;
            wy      <= '0;
            wz      <= '0;
            wfunc   <= '0;
            wtag    <= '0;
            o_valid <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_z     <= '0;
            o_func  <= '0;
            o_tag   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        wx    <= i_x;
                        wy    <= i_y;
                        wz    <= i_z;
                        wfunc <= i_func;
                        wtag  <= i_tag;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    wx  <= nx;
                    wy  <= ny;
                    wz  <= nz;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        o_x     <= nx;
                        o_y     <= ny;
                        o_z     <= nz;
                        o_func  <= wfunc;
                        o_tag   <= wtag;
                        o_valid <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // retiring and accepting can share one edge
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (i_valid) begin
                            wx    <= i_x;
                            wy    <= i_y;
                            wz    <= i_z;
                            wfunc <= i_func;
                            wtag  <= i_tag;
                            cnt   <= '0;
                            state <= ST_RUN;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Bench for the folded CORDIC engine: directed table, backpressure,
// asynchronous reset abort and a random back-to-back stream.
module tb_cordic_iter_engine;

    localparam int N  = 12;
    localparam int W  = 18;
    localparam int FW = 1;
    localparam int TW = 4;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n;
    logic                  i_valid;
    logic                  o_ready;
    logic [FW-1:0]         i_func;
    logic [TW-1:0]         i_tag;
    logic signed [W-1:0]   i_x;
    logic signed [W-1:0]   i_y;
    logic signed [W-1:0]   i_z;
    logic                  o_valid;
    logic                  i_ready;
    logic signed [W-1:0]   o_x;
    logic signed [W-1:0]   o_y;
    logic signed [W-1:0]   o_z;
    logic [FW-1:0]         o_func;
    logic [TW-1:0]         o_tag;

    cordic_iter_engine #(
        .NUM_ITER      (N),
        .DATA_OP_WIDTH (W),
        .FUNC_WIDTH    (FW),
        .TAG_WIDTH     (TW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_func  (i_func),
        .i_tag   (i_tag),
        .i_x     (i_x),
        .i_y     (i_y),
        .i_z     (i_z),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_x     (o_x),
        .o_y     (o_y),
        .o_z     (o_z),
        .o_func  (o_func),
        .o_tag   (o_tag)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ang [N];

    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int func;
        int x, y, z;
        int tag;
        int ex, ey, ez;
        int txy, tz;
    } vec_t;

    typedef struct {
        int x, y, z, tag;
    } exp_t;

    function automatic int wrap(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: the CORDIC recurrence in plain integer arithmetic.
    task automatic model(input int func, input int xi, input int yi,
                         input int zi, output int xo, output int yo,
                         output int zo);
        int x, y, z, xs, ys;
        bit cw;
        x = wrap(xi);
        y = wrap(yi);
        z = wrap(zi);
        for (int i = 0; i < N; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (func == 1) cw = ((x < 0) == (y < 0));
            else           cw = (z < 0);
            if (cw) begin
                x = wrap(x + ys); y = wrap(y - xs); z = wrap(z + ang[i]);
            end else begin
                x = wrap(x - ys); y = wrap(y + xs); z = wrap(z - ang[i]);
            end
        end
        xo = x; yo = y; zo = z;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act,
                             input int exp, input int tol);
        checks++;
        if (iabs(act - exp) > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d +/- %0d",
                     name, act, exp, tol);
        end
    endtask

    task automatic drive(input int func, input int x, input int y,
                         input int z, input int tag);
        i_func  = FW'(func);
        i_x     = W'(x);
        i_y     = W'(y);
        i_z     = W'(z);
        i_tag   = TW'(tag);
        i_valid = 1'b1;
    endtask

    // Called #1 after an edge with o_ready high; returns edges to o_valid.
    task automatic accept_and_wait(output int lat);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    vec_t vt [3];
    exp_t q [$];

    initial begin
        int lat, mx, my, mz, seen, got, last_cyc;
        bit drv_done;
        exp_t e;

        for (int i = 0; i < N; i++)
            ang[i] = $rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** (W - 1))
                           / 3.14159265358979323846 + 0.5);

        vt[0] = '{0,  10000,     0,  32768, 4'h5,  11645,  11645,     0, 16, 24};
        vt[1] = '{1,  10000, 10000,      0, 4'hA,  23290,      0, 32768, 16, 24};
        vt[2] = '{0, -20000,     0, -32768, 4'h3, -23290,  23290,     0, 16, 24};

        i_rst_n = 1'b0;
        i_ready = 1'b1;
        i_valid = 1'b0;
        drive(0, 0, 0, 0, 0);
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_x", int'(o_x), 0);
        check("rst_o_tag", int'(o_tag), 0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("idle_o_ready", int'(o_ready), 1);

        for (int k = 0; k < 3; k++) begin
            model(vt[k].func, vt[k].x, vt[k].y, vt[k].z, mx, my, mz);
            drive(vt[k].func, vt[k].x, vt[k].y, vt[k].z, vt[k].tag);
            accept_and_wait(lat);
            check($sformatf("v%0d_latency", k), lat, N);
            check_tol($sformatf("v%0d_x_approx", k), int'(o_x), vt[k].ex, vt[k].txy);
            check_tol($sformatf("v%0d_y_approx", k), int'(o_y), vt[k].ey, vt[k].txy);
            check_tol($sformatf("v%0d_z_approx", k), int'(o_z), vt[k].ez, vt[k].tz);
            check($sformatf("v%0d_x_exact", k), int'(o_x), mx);
            check($sformatf("v%0d_y_exact", k), int'(o_y), my);
            check($sformatf("v%0d_z_exact", k), int'(o_z), mz);
            check($sformatf("v%0d_tag", k), int'(o_tag), vt[k].tag);
            check($sformatf("v%0d_func", k), int'(o_func), vt[k].func);
            @(posedge i_clk); #1;
            check($sformatf("v%0d_retire", k), int'(o_valid), 0);
        end

        // backpressure, then simultaneous retire and accept
        i_ready = 1'b0;
        model(0, 12000, -3000, 20000, mx, my, mz);
        drive(0, 12000, -3000, 20000, 4'h7);
        accept_and_wait(lat);
        check("bp_latency", lat, N);
        drive(0, -5000, 7000, -9000, 4'h9);
        for (int c = 0; c < 5; c++) begin
            check("bp_o_ready", int'(o_ready), 0);
            check("bp_o_valid", int'(o_valid), 1);
            check("bp_hold_x", int'(o_x), mx);
            check("bp_hold_y", int'(o_y), my);
            check("bp_hold_z", int'(o_z), mz);
            check("bp_hold_tag", int'(o_tag), 7);
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
        #1;
        check("bp_ready_comb", int'(o_ready), 1);
        model(0, -5000, 7000, -9000, mx, my, mz);
        accept_and_wait(lat);
        check("bp_next_latency", lat, N);
        check("bp_next_x", int'(o_x), mx);
        check("bp_next_y", int'(o_y), my);
        check("bp_next_z", int'(o_z), mz);
        check("bp_next_tag", int'(o_tag), 9);
        @(posedge i_clk); #1;

        // asynchronous reset in the middle of an operation
        drive(0, 15000, 4000, 25000, 4'hC);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (6) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("arst_o_valid", int'(o_valid), 0);
        check("arst_o_x", int'(o_x), 0);
        check("arst_o_y", int'(o_y), 0);
        check("arst_o_z", int'(o_z), 0);
        check("arst_o_tag", int'(o_tag), 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        #1;
        check("arst_o_ready", int'(o_ready), 1);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        check("arst_no_result", seen, 0);
        @(posedge i_clk); #1;

        // random back-to-back rotation stream
        got = 0;
        last_cyc = -1;
        drv_done = 0;
        fork
            begin
                int n, tries, rx, ry, rz, rt;
                bit acc;
                n = 0;
                tries = 0;
                while (n < 20 && tries < 2000) begin
                    rx = int'($urandom_range(60000)) - 30000;
                    ry = int'($urandom_range(60000)) - 30000;
                    rz = int'($urandom_range(131071)) - 65536;
                    rt = int'($urandom_range(15));
                    drive(0, rx, ry, rz, rt);
                    acc = 0;
                    while (!acc && tries < 2000) begin
                        acc = o_ready;
                        @(posedge i_clk); #1;
                        tries++;
                    end
                    if (acc) begin
                        model(0, rx, ry, rz, e.x, e.y, e.z);
                        e.tag = rt;
                        q.push_back(e);
                        n++;
                    end
                end
                i_valid = 1'b0;
                drv_done = 1;
            end
            begin
                for (int c = 0; c < 20 * (N + 1) + 80 && got < 20; c++) begin
                    @(negedge i_clk);
                    if (o_valid) begin
                        if (q.size() == 0) begin
                            check("stream_unexpected", 1, 0);
                        end else begin
                            e = q.pop_front();
                            check("stream_x", int'(o_x), e.x);
                            check("stream_y", int'(o_y), e.y);
                            check("stream_z", int'(o_z), e.z);
                            check("stream_tag", int'(o_tag), e.tag);
                        end
                        if (last_cyc >= 0)
                            check("stream_spacing", cyc - last_cyc, N + 1);
                        last_cyc = cyc;
                        got++;
                    end
                end
            end
        join
        check("stream_count", got, 20);
        check("stream_driver_done", int'(drv_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
